spi_packet_assembler: RTL

Parametrised byte-serial packet receiver between the SPI slave and the FIB table. It consumes one byte per RX_valid strobe and assembles interest packets (metadata + prefix) and data packets (metadata + prefix + payload). It presents each completed packet on a registered valid/ready interface. It adds behaviour the fixed-width SPI->FIB path lacks:
- packet-type decode
- configurable prefix and payload widths
- an inter-byte timeout
- output backpressure with overflow detection

---
 rtl/ndn_pkg.sv | 15 +
 rtl/spi_packet_assembler_shift.sv | 27 ++
 rtl/spi_packet_assembler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ndn_pkg.sv
// Shared types and constants for the SPI-side packet assembler.
package ndn_pkg;

    localparam int PKT_TYPE_BIT = 7;
    localparam int META_BYTES   = 1;

    typedef enum logic [1:0] {IDLE, PREFIX, DATA} rx_state_t;

    // Total strobes needed for one packet of the given type.
    function automatic int packet_length(input logic is_data, input int prefix_bytes,
                                         input int data_bytes);
        return META_BYTES + prefix_bytes + (is_data ? data_bytes : 0);
    endfunction

endpackage

// File: rtl/spi_packet_assembler_shift.sv
// MSB-first byte shift register; shift_o is the value it would hold after one shift.
module byte_shift_reg #(
    parameter int NBYTES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic [7:0]          byte_i,
    output logic [8*NBYTES-1:0] q_o,
    output logic [8*NBYTES-1:0] shift_o
);

    logic [8*NBYTES-1:0] q_q;
    logic [8*NBYTES+7:0] wide;

    // Concatenate then truncate so NBYTES=1 needs no special case.
    assign wide    = {q_q, byte_i};
    assign shift_o = wide[8*NBYTES-1:0];
    assign q_o     = q_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) q_q <= '0;
        else if (en_i)    q_q <= shift_o;
    end

endmodule

// File: rtl/spi_packet_assembler.sv
// Byte-serial interest/data packet assembler with timeout and held valid/ready output.
module spi_packet_assembler
    import ndn_pkg::*;
#(
    parameter int PREFIX_BYTES   = 8,
    parameter int DATA_BYTES     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    RX_valid,
    input  logic [7:0]              data_SPI_to_FIB,
    input  logic                    pkt_ready,
    output logic                    pkt_valid,
    output logic                    pkt_is_data,
    output logic [7:0]              pkt_metadata,
    output logic [8*PREFIX_BYTES-1:0] pkt_prefix,
    output logic [8*DATA_BYTES-1:0]   pkt_data,
    output logic                    err_timeout,
    output logic                    err_overflow,
    output logic [15:0]             pkt_count
);

    localparam int MAXB   = (PREFIX_BYTES > DATA_BYTES) ? PREFIX_BYTES : DATA_BYTES;
    localparam int CNT_W  = $clog2(MAXB + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  PREFIX_LAST = CNT_W'(PREFIX_BYTES - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST   = CNT_W'(DATA_BYTES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST   = IDLE_W'(TIMEOUT_CYCLES - 2);

    rx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [7:0]        meta_q, meta_d;
    logic              pre_en, pay_en, asm_clr, done, timeout;

    logic [8*PREFIX_BYTES-1:0] pre_q, pre_shift;
    logic [8*DATA_BYTES-1:0]   pay_q, pay_shift;

    logic                      valid_q, is_data_q, to_q, ov_q;
    logic [7:0]                meta_out_q;
    logic [8*PREFIX_BYTES-1:0] prefix_out_q;
    logic [8*DATA_BYTES-1:0]   data_out_q;
    logic [15:0]               count_q;

    byte_shift_reg #(.NBYTES(PREFIX_BYTES)) u_prefix (
        .clk(clk), .rst(rst), .clr_i(asm_clr), .en_i(pre_en),
        .byte_i(data_SPI_to_FIB), .q_o(pre_q), .shift_o(pre_shift)
    );

    byte_shift_reg #(.NBYTES(DATA_BYTES)) u_payload (
        .clk(clk), .rst(rst), .clr_i(asm_clr), .en_i(pay_en),
        .byte_i(data_SPI_to_FIB), .q_o(pay_q), .shift_o(pay_shift)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            idle_q     <= '0;
            meta_q     <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            idle_q     <= idle_d;
            meta_q     <= meta_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        idle_d     = idle_q;
        meta_d     = meta_q;
        pre_en     = 1'b0;
        pay_en     = 1'b0;
        asm_clr    = 1'b0;
        done       = 1'b0;
        timeout    = 1'b0;
        unique case (state_q)
            IDLE: begin
                idle_d = '0;
                if (RX_valid) begin
                    meta_d     = data_SPI_to_FIB;
                    byte_cnt_d = '0;
                    asm_clr    = 1'b1;
                    state_d    = PREFIX;
                end
            end
            PREFIX, DATA: begin
                if (RX_valid) begin
                    idle_d     = '0;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (state_q == PREFIX) begin
                        pre_en = 1'b1;
                        if (byte_cnt_q == PREFIX_LAST) begin
                            byte_cnt_d = '0;
                            if (meta_q[PKT_TYPE_BIT]) begin
                                state_d = DATA;
                            end else begin
                                done    = 1'b1;
                                state_d = IDLE;
                            end
                        end
                    end else begin
                        pay_en = 1'b1;
                        if (byte_cnt_q == DATA_LAST) begin
                            done    = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end else if (idle_q == IDLE_LAST) begin
                    // Partial packet is abandoned; the held output is left alone.
                    timeout = 1'b1;
                    idle_d  = '0;
                    state_d = IDLE;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output holding register: a completion loads only if the slot is free or being handed off.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            is_data_q    <= 1'b0;
            meta_out_q   <= '0;
            prefix_out_q <= '0;
            data_out_q   <= '0;
            count_q      <= '0;
            to_q         <= 1'b0;
            ov_q         <= 1'b0;
        end else begin
            to_q <= timeout;
            ov_q <= 1'b0;
            if (done) begin
                if (!valid_q || pkt_ready) begin
                    valid_q      <= 1'b1;
                    is_data_q    <= meta_q[PKT_TYPE_BIT];
                    meta_out_q   <= meta_q;
                    prefix_out_q <= (state_q == PREFIX) ? pre_shift : pre_q;
                    data_out_q   <= meta_q[PKT_TYPE_BIT] ? pay_shift : '0;
                    count_q      <= count_q + 16'd1;
                end else begin
                    ov_q <= 1'b1;
                end
            end else if (pkt_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign pkt_valid    = valid_q;
    assign pkt_is_data  = is_data_q;
    assign pkt_metadata = meta_out_q;
    assign pkt_prefix   = prefix_out_q;
    assign pkt_data     = data_out_q;
    assign err_timeout  = to_q;
    assign err_overflow = ov_q;
    assign pkt_count    = count_q;

endmodule
